pll_lock_sequencer: RTL

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, waits for a stable lock,
// then releases downstream reset. Retries on lock timeout, fails after
// MAX_RETRY consecutive timeouts.
//
// Ports:
//   refclk      in   sole clock
//   rst         in   synchronous active-high reset
//   pll_locked  in   raw PLL lock, asynchronous to refclk
//   pll_rst     out  PLL reset, active high
//   sys_rst     out  downstream reset, active high
//   ready       out  high only in RUN
//   fail        out  high only in FAIL
//   relock_cnt  out  lock losses seen in RUN, saturating at 255
//
// Optional feature macro: PLL_SEQ_AUTORELOCK_EN
//   defined   : lock loss in RUN restarts the PLL reset sequence
//   undefined : lock loss in RUN is fatal (FAIL)
module pll_lock_sequencer #(
    parameter int RST_HOLD_CYC = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 4
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] relock_cnt
);

    localparam logic [15:0] HOLD_LAST   = 16'(RST_HOLD_CYC - 1);
    localparam logic [19:0] TMO_LAST    = 20'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE - 1);
    localparam logic [3:0]  RETRY_LAST  = 4'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t      state;
    logic        sync1;
    logic        sync2;
    logic        lock_s;
    logic [15:0] hold_cnt;
    logic [19:0] tmo_cnt;
    logic [15:0] stable_cnt;
    logic [3:0]  retry_cnt;

    assign lock_s = sync2;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state      <= ST_PLL_RST;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            hold_cnt   <= '0;
            tmo_cnt    <= '0;
            stable_cnt <= '0;
            retry_cnt  <= '0;
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
            relock_cnt <= '0;
        end else begin
            // Only these two flops ever see the raw pll_locked.
            sync1 <= pll_locked;
            sync2 <= sync1;

            unique case (state)
                ST_PLL_RST: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_WAIT_LOCK;
                        hold_cnt <= '0;
                        tmo_cnt  <= '0;
                        pll_rst  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end

                ST_WAIT_LOCK: begin
                    // Lock wins over a timeout expiring on the same edge.
                    if (lock_s) begin
                        state      <= ST_STABLE;
                        stable_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        retry_cnt <= retry_cnt + 4'd1;
                        tmo_cnt   <= '0;
                        if (retry_cnt == RETRY_LAST) begin
                            state <= ST_FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state    <= ST_PLL_RST;
                            hold_cnt <= '0;
                        end
                        pll_rst <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 20'd1;
                    end
                end

                ST_STABLE: begin
                    // A drop on the completion edge still aborts.
                    if (!lock_s) begin
                        state   <= ST_WAIT_LOCK;
                        tmo_cnt <= '0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state     <= ST_RUN;
                        retry_cnt <= '0;
                        sys_rst   <= 1'b0;
                        ready     <= 1'b1;
                    end else begin
                        stable_cnt <= stable_cnt + 16'd1;
                    end
                end

                ST_RUN: begin
                    if (!lock_s) begin
                        if (relock_cnt != 8'hFF) begin
                            relock_cnt <= relock_cnt + 8'd1;
                        end
                        sys_rst <= 1'b1;
                        ready   <= 1'b0;
                        pll_rst <= 1'b1;
`ifdef PLL_SEQ_AUTORELOCK_EN
                        state    <= ST_PLL_RST;
                        hold_cnt <= '0;
`else
                        state <= ST_FAIL;
                        fail  <= 1'b1;
`endif
                    end
                end

                ST_FAIL: begin
                    pll_rst <= 1'b1;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                    fail    <= 1'b1;
                end

                default: begin
                    state    <= ST_PLL_RST;
                    hold_cnt <= '0;
                    pll_rst  <= 1'b1;
                    sys_rst  <= 1'b1;
                    ready    <= 1'b0;
                    fail     <= 1'b0;
                end
            endcase
        end
    end

endmodule
